// File: rtl/io_port_agent.sv
// -----------------------------------------------------------------------------
// io_port_agent
//
// Bridges a processor's memory-mapped I/O ports to an external
// valid/ready stream in each direction.
//
//   Output path: a 4-entry FIFO. The processor writes into it through
//   out_port/out_port_write, and an external consumer drains it through
//   ext_out_data/ext_out_valid/ext_out_ready. If a write arrives while the
//   FIFO is full and no pop happens in the same cycle, the write is dropped
//   and the sticky overflow flag is set.
//
//   Input path: a 3-state FSM (IDLE -> IRQ -> WAIT_ACK). In IDLE it captures
//   one external word into input_port. It then raises interrupt_signal for
//   one cycle and waits for in_port_read before it accepts another word.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous active-low reset
//   out_port          [15:0] processor output-port value
//   out_port_write    processor write strobe
//   ext_out_data      [15:0] FIFO head entry
//   ext_out_valid     FIFO non-empty
//   ext_out_ready     external consumer accepts head entry
//   ext_in_data       [15:0] external producer word
//   ext_in_valid      external producer offers a word
//   ext_in_ready      agent accepts a word (IDLE)
//   input_port        [15:0] captured word for the processor
//   interrupt_signal  one-cycle interrupt request
//   in_port_read      processor has consumed input_port
//   overflow          sticky: an output-port write was dropped
// -----------------------------------------------------------------------------
module io_port_agent (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] out_port,
   input  logic        out_port_write,
   output logic [15:0] ext_out_data,
   output logic        ext_out_valid,
   input  logic        ext_out_ready,
   input  logic [15:0] ext_in_data,
   input  logic        ext_in_valid,
   output logic        ext_in_ready,
   output logic [15:0] input_port,
   output logic        interrupt_signal,
   input  logic        in_port_read,
   output logic        overflow
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_IRQ      = 2'd1,
      ST_WAIT_ACK = 2'd2
   } state_t;

   // ---------------------------------------------------------------- output path
   logic [15:0] mem_q [4];
   logic [15:0] mem_d [4];
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q,  count_d;
   logic        overflow_q, overflow_d;
   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        pop;

   always_comb begin
      fifo_full  = (count_q == 3'd4);
      fifo_empty = (count_q == 3'd0);
      // A pop is only real when the head is valid, so an empty FIFO ignores
      // ext_out_ready.
      pop        = ext_out_ready && !fifo_empty;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts
      // the write.
      push       = out_port_write && (!fifo_full || pop);

      for (int i = 0; i < 4; i++) begin
         mem_d[i] = mem_q[i];
      end
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (push) begin
         mem_d[wr_ptr_q] = out_port;
         wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
      if (out_port_write && !push) begin
         overflow_d = 1'b1;
      end
   end

   // Storage entries are reset so that the head reads zero while in reset.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_mem
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               mem_q[gi] <= 16'h0000;
            end else begin
               mem_q[gi] <= mem_d[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
         count_q    <= 3'd0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign ext_out_valid = (count_q != 3'd0);
   assign ext_out_data  = mem_q[rd_ptr_q];
   assign overflow      = overflow_q;

   // ----------------------------------------------------------------- input path
   state_t      state_q, state_d;
   logic [15:0] input_port_q, input_port_d;

   always_comb begin
      state_d      = state_q;
      input_port_d = input_port_q;
      case (state_q)
         ST_IDLE: begin
            if (ext_in_valid) begin
               input_port_d = ext_in_data;
               state_d      = ST_IRQ;
            end
         end
         ST_IRQ: begin
            // An acknowledge during the interrupt cycle skips WAIT_ACK.
            state_d = in_port_read ? ST_IDLE : ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (in_port_read) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         input_port_q <= 16'h0000;
      end else begin
         state_q      <= state_d;
         input_port_q <= input_port_d;
      end
   end

   assign ext_in_ready     = (state_q == ST_IDLE);
   assign interrupt_signal = (state_q == ST_IRQ);
   assign input_port       = input_port_q;

endmodule

// File: doc/io_port_agent.md
IO_PORT_AGENT -- requirements
Module: io_port_agent

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low. Ports are named clk and rst.
REQ-002 clk  in  1  rising-edge clock, shared with the processor.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 out_port  in  16  processor output-port value.
REQ-005 out_port_write  in  1  one-cycle strobe: processor writes out_port this cycle.
REQ-006 ext_out_data  out  16  head entry of the output FIFO.
REQ-007 ext_out_valid  out  1  output FIFO non-empty.
REQ-008 ext_out_ready  in  1  external consumer accepts the head entry.
REQ-009 ext_in_data  in  16  external producer data word.
REQ-010 ext_in_valid  in  1  external producer offers ext_in_data.
REQ-011 ext_in_ready  out  1  agent accepts ext_in_data.
REQ-012 input_port  out  16  captured word presented to the processor input port.
REQ-013 interrupt_signal  out  1  one-cycle interrupt request to the processor.
REQ-014 in_port_read  in  1  processor acknowledges that it has consumed input_port.
REQ-015 overflow  out  1  sticky flag: an output-port write was dropped.

Function -- output path (processor -> external)
REQ-016 SHALL buffer out_port writes in a 4-entry FIFO.
- 2-bit read and write pointers, wrapping 3->0.
- 3-bit occupancy count, range 0..4.
REQ-017 SHALL push out_port on a clk edge when out_port_write=1 and the FIFO is not full.
REQ-018 SHALL pop on a clk edge when ext_out_valid=1 and ext_out_ready=1.
REQ-019 ext_out_valid SHALL equal (count!=0), and ext_out_data SHALL equal the entry at the read pointer.
- Both are registered-state derived; neither has a combinational path from any input.
REQ-020 Full with push and pop in the same cycle: both SHALL occur; count stays 4 and the write is not dropped.
REQ-021 Empty with push and pop in the same cycle: the pop SHALL be ignored (ext_out_valid=0); the push completes and count becomes 1.
REQ-022 Write while full with no pop: the write SHALL be dropped, FIFO contents unchanged, overflow set to 1.
- overflow stays 1 until reset.
REQ-023 FIFO order SHALL be strict first-in, first-out; first word out appears one cycle after its push.

Function -- input path (external -> processor)
REQ-024 SHALL implement a 3-state FSM: IDLE, IRQ, WAIT_ACK.
REQ-025 IDLE: ext_in_ready=1. On ext_in_valid=1, SHALL load ext_in_data into input_port and go to IRQ.
REQ-026 IRQ: interrupt_signal=1 for exactly this one cycle; ext_in_ready=0.
- Next state is WAIT_ACK, or IDLE if in_port_read=1 this cycle.
REQ-027 WAIT_ACK: ext_in_ready=0 and interrupt_signal=0. On in_port_read=1, SHALL go to IDLE.
REQ-028 in_port_read while in IDLE SHALL be ignored.
REQ-029 input_port SHALL change only on a capture in IDLE; it holds its value through IRQ, WAIT_ACK and the following IDLE.
REQ-030 Minimum spacing between two captures SHALL be 2 cycles (IDLE->IRQ->IDLE when in_port_read coincides with IRQ).
REQ-031 ext_in_ready and interrupt_signal SHALL be decoded from the state register only.
REQ-032 The output path and input path SHALL be fully independent; simultaneous activity on both has no interaction.

Reset
REQ-033 When rst=0, immediately and independent of clk, SHALL force:
- FIFO pointers and count = 0;
- ext_out_valid=0, ext_out_data=16'h0000;
- overflow=0;
- FSM=IDLE, input_port=16'h0000, interrupt_signal=0.
REQ-034 While in reset, ext_in_ready SHALL read 1 (IDLE decode), but no capture occurs until the first clk edge after rst returns to 1.
REQ-035 Reset asserted mid-transfer SHALL discard buffered FIFO words and any pending interrupt/acknowledge without producing further output.

Verification
REQ-036 Write 16'h0001..16'h0004 on 4 consecutive cycles, ext_out_ready=0 -> count 4, ext_out_valid=1, ext_out_data=16'h0001, overflow=0.
REQ-037 From that full state, write 16'h0005 with ext_out_ready=0 -> overflow=1, head still 16'h0001. Then set ext_out_ready=1 -> words 1,2,3,4 drain in 4 cycles, then ext_out_valid=0.
REQ-038 Full FIFO, write 16'hAAAA with ext_out_ready=1 in the same cycle -> 16'h0001 popped, 16'hAAAA accepted, overflow stays 0. Drain order is 2,3,4,AAAA.
REQ-039 ext_in_valid=1, ext_in_data=16'hBEEF in IDLE -> next cycle input_port=16'hBEEF and interrupt_signal=1 for one cycle. ext_in_ready stays 0 until in_port_read is pulsed, then returns to 1 the cycle after.
REQ-040 Reset asserted asynchronously (between clk edges) while in WAIT_ACK with 3 FIFO words held -> immediately ext_out_valid=0, input_port=16'h0000, ext_in_ready=1, interrupt_signal=0.
REQ-041 in_port_read=1 during the IRQ cycle with ext_in_valid held high (16'h1111 then 16'h2222) -> captures occur 2 cycles apart with two one-cycle interrupt_signal pulses.
